axicb_ostd_sched: RTL
=====================

AXICB_OSTD_SCHED -- requirements
Module: axicb_ostd_sched

Interface
REQ-001 SHALL have parameter AXI_ID_W, default 8: ID width in bits.
REQ-002 SHALL have parameter SLV_NB, default 4: number of slaves; slave index is one-hot.
REQ-003 SHALL have parameter MST_OSTDREQ_NUM, default 4: max total outstanding requests; also the number of tracked IDs (NB_ID).
REQ-004 SHALL have parameter MAX_PER_ID, default 2: max outstanding requests per ID.
REQ-005 SHALL have parameter MST_ID_MASK [AXI_ID_W-1:0], default 'h00: master ID mask, XORed onto the ID to unmask it.
REQ-006 SHALL have port aclk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port srst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port i_valid  input  1  upstream address valid.
REQ-009 SHALL have port i_ready  output  1  upstream address ready.
REQ-010 SHALL have port i_id  input  AXI_ID_W  address ID.
REQ-011 SHALL have port i_ix  input  SLV_NB  targeted slave, one-hot.
REQ-012 SHALL have port o_valid  output  1  gated valid to the switch.
REQ-013 SHALL have port o_ready  input  1  switch ready.
REQ-014 SHALL have port c_end  input  1  completion finished (last beat handshaked).
REQ-015 SHALL have port c_id  input  AXI_ID_W  ID of the finished completion.
REQ-016 SHALL have port ostd_cnt  output  $clog2(MST_OSTDREQ_NUM+1)  total outstanding requests.
REQ-017 SHALL have port err  output  1  sticky protocol error.

Function
REQ-018 SHALL compute idx = low $clog2(NB_ID) bits of (i_id ^ MST_ID_MASK); completion index is computed the same way from c_id.
REQ-019 SHALL keep, per ID: cnt[i] (0..MAX_PER_ID) and tag[i] (SLV_NB bits); tag[i] is valid only while cnt[i]>0.
REQ-020 SHALL compute allow = (ostd_cnt < MST_OSTDREQ_NUM) & (cnt[idx] < MAX_PER_ID) & (cnt[idx]==0 | tag[idx]==i_ix).
REQ-021 SHALL drive o_valid = i_valid & allow and i_ready = o_ready & allow, both combinational.
REQ-022 SHALL derive allow from registered state only; a same-cycle c_end SHALL NOT unblock the request (no comb path c_end -> i_ready).
REQ-023 SHALL define issue = i_valid & i_ready; on issue, cnt[idx]+1, tag[idx] <= i_ix, ostd_cnt+1; effect visible next cycle.
REQ-024 SHALL, on c_end with cnt[cidx]>0, apply cnt[cidx]-1 and ostd_cnt-1; tag[cidx] is cleared to 0 when cnt reaches 0.
REQ-025 SHALL, on simultaneous issue and c_end on the same ID, leave cnt and ostd_cnt unchanged and set tag to i_ix.
REQ-026 SHALL, on simultaneous issue and c_end on different IDs, update each per-ID counter independently and leave ostd_cnt unchanged.
REQ-027 SHALL, on c_end with cnt[cidx]==0, leave all counters unchanged and set err to 1.
REQ-028 SHALL hold err at 1 until reset.
REQ-029 SHALL never wrap counters; the saturation boundary is enforced by allow.
REQ-030 SHALL treat i_ix with zero or multiple bits set as a plain tag value, with no error raised.

Reset
REQ-031 SHALL, with srst=1 at a clock edge, clear all cnt, tag, ostd_cnt and err to 0, overriding any same-cycle issue or c_end.
REQ-032 SHALL, while srst=1, still drive o_valid and i_ready combinationally per REQ-021 from the cleared state.
REQ-033 SHALL drop all outstanding tracking on a reset mid-operation; no completion replay.

Configuration
REQ-034 SHALL, with AXICB_OSTD_HAZARD_CNT_EN defined, add output port hazard_cnt[15:0].
REQ-035 SHALL increment hazard_cnt each cycle i_valid=1 and the request is blocked solely by the tag mismatch.
REQ-036 SHALL saturate hazard_cnt at 16'hFFFF and clear it on srst.
REQ-037 SHALL, without AXICB_OSTD_HAZARD_CNT_EN, have no hazard_cnt port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-038 SHALL cover: issue IDs 0,1,2,3 to slave 4'b0001, o_ready=1 -> ostd_cnt=4; fifth request blocked (i_ready=0) until one c_end, then accepted the cycle after.
REQ-039 SHALL cover: ID 1 to slave 4'b0001, then ID 1 to slave 4'b0010 -> second blocked; after c_end c_id=1, accepted the next cycle with tag=4'b0010.
REQ-040 SHALL cover: ID 2 issued twice to the same slave (MAX_PER_ID=2) -> third ID 2 request blocked; ID 3 request still accepted.
REQ-041 SHALL cover: issue ID 0 and c_end c_id=0 in the same cycle while cnt[0]=1 -> cnt[0] stays 1 and ostd_cnt is unchanged.
REQ-042 SHALL cover: c_end c_id=3 with cnt[3]=0 -> err=1 and stays 1; srst pulse -> err=0, ostd_cnt=0.
REQ-043 SHALL cover, with AXICB_OSTD_HAZARD_CNT_EN: a tag-mismatch stall held for 10 cycles -> hazard_cnt=10.

Source files
------------

// File: rtl/axicb_ostd_sched.sv
// axicb_ostd_sched: per-ID outstanding request scheduler that holds back a request while the same ID is still outstanding to a different slave
//   aclk/srst          clock, synchronous active-high reset
//   i_valid/i_ready    upstream address handshake, i_id address ID, i_ix one-hot target slave
//   o_valid/o_ready    gated handshake toward the switch
//   c_end/c_id         completion finished and its ID
//   ostd_cnt           total outstanding requests; err sticky completion-without-request error
//   hazard_cnt         tag-mismatch stall cycle counter, present only with AXICB_OSTD_HAZARD_CNT_EN
module axicb_ostd_sched #(
    parameter int AXI_ID_W = 8,
    parameter int SLV_NB = 4,
    parameter int MST_OSTDREQ_NUM = 4,
    parameter int MAX_PER_ID = 2,
    parameter logic [AXI_ID_W-1:0] MST_ID_MASK = 'h00
) (
    input  logic aclk,
    input  logic srst,
    input  logic i_valid,
    output logic i_ready,
    input  logic [AXI_ID_W-1:0] i_id,
    input  logic [SLV_NB-1:0] i_ix,
    output logic o_valid,
    input  logic o_ready,
    input  logic c_end,
    input  logic [AXI_ID_W-1:0] c_id,
    output logic [$clog2(MST_OSTDREQ_NUM+1)-1:0] ostd_cnt,
`ifdef AXICB_OSTD_HAZARD_CNT_EN
    output logic [15:0] hazard_cnt,
`endif
    output logic err
);
    localparam int NB_ID = MST_OSTDREQ_NUM;
    localparam int IDX_W = NB_ID > 1 ? $clog2(NB_ID) : 1;
    localparam int CNT_W = $clog2(MAX_PER_ID + 1);
    localparam int OW = $clog2(MST_OSTDREQ_NUM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PER_ID);
    localparam logic [OW-1:0] OSTD_MAX = OW'(MST_OSTDREQ_NUM);
    logic [CNT_W-1:0] cnt [NB_ID];
    logic [SLV_NB-1:0] tag [NB_ID];
    logic [AXI_ID_W-1:0] id_um, cid_um;
    logic [IDX_W-1:0] idx, cidx;
    logic ostd_ok, cnt_ok, tag_ok, allow, issue, done, bad;
    logic [NB_ID-1:0] inc, dec;
    assign id_um = i_id ^ MST_ID_MASK;
    assign cid_um = c_id ^ MST_ID_MASK;
    assign idx = id_um[IDX_W-1:0];
    assign cidx = cid_um[IDX_W-1:0];
    // allow only looks at registered state, so a completion never unblocks in its own cycle
    assign ostd_ok = ostd_cnt < OSTD_MAX;
    assign cnt_ok = cnt[idx] < CNT_MAX;
    assign tag_ok = cnt[idx] == '0 || tag[idx] == i_ix;
    assign allow = ostd_ok && cnt_ok && tag_ok;
    assign o_valid = i_valid && allow;
    assign i_ready = o_ready && allow;
    assign issue = i_valid && i_ready;
    assign done = c_end && cnt[cidx] != '0;
    assign bad = c_end && cnt[cidx] == '0;
    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NB_ID; i++) begin
            inc[i] = issue && idx == IDX_W'(i);
            dec[i] = done && cidx == IDX_W'(i);
        end
    end
    always_ff @(posedge aclk) begin
        if (srst) begin
            for (int i = 0; i < NB_ID; i++) begin
                cnt[i] <= '0;
                tag[i] <= '0;
            end
            ostd_cnt <= '0;
            err <= 1'b0;
        end else begin
            for (int i = 0; i < NB_ID; i++) begin
                cnt[i] <= inc[i] == dec[i] ? cnt[i] : inc[i] ? cnt[i] + CNT_W'(1) : cnt[i] - CNT_W'(1);
                tag[i] <= inc[i] ? i_ix : (dec[i] && cnt[i] == CNT_W'(1)) ? '0 : tag[i];
            end
            ostd_cnt <= issue == done ? ostd_cnt : issue ? ostd_cnt + OW'(1) : ostd_cnt - OW'(1);
            err <= err || bad;
        end
    end
`ifdef AXICB_OSTD_HAZARD_CNT_EN
    always_ff @(posedge aclk) begin
        if (srst) hazard_cnt <= '0;
        else if (i_valid && ostd_ok && cnt_ok && !tag_ok && hazard_cnt != 16'hFFFF) hazard_cnt <= hazard_cnt + 16'd1;
    end
`endif
endmodule
